systolic_feeder: RTL and testbench

Edge feeder for the systolic PE array: buffers incoming activation/weight vectors and drives the array's west edge (activations plus fire, one lane per row) and north edge (weights, one lane per column). Skews each lane by its index so operands meet in the correct PE on the correct cycle. Flushes the skew pipeline at the end of each tile and pulses `done`. It is the transmitter side of the PE `fire`/`in_a`/`in_w` interface.

---
 rtl/systolic_feeder.sv | 160 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Systolic array edge feeder: a vector FIFO feeding per-lane skew chains on the west (activations and fire)
// and north (weights) edges, with a tile flush and a done pulse.

module systolic_feeder_lane #(
  parameter int STAGES = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       out_vld,
  output logic [7:0] out_data
);
  logic [STAGES-1:0]      vld_q;
  logic [STAGES-1:0][7:0] dat_q;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][7:0]   dat_pipe;

  assign vld_pipe = {vld_q, in_vld};
  assign dat_pipe = {dat_q, in_data};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      dat_q <= dat_pipe[STAGES-1:0];
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = dat_pipe[STAGES];
endmodule

module systolic_feeder #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROWS*8-1:0] in_a,
  input  logic [COLS*8-1:0] in_w,
  input  logic              in_last,
  output logic [ROWS*8-1:0] out_a,
  output logic [ROWS-1:0]   out_fire,
  output logic [COLS*8-1:0] out_w,
  output logic              busy,
  output logic              done
);
  localparam int L  = (ROWS > COLS) ? ROWS : COLS;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(L) + 1;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  typedef struct packed {
    logic                 last;
    logic [COLS-1:0][7:0] w;
    logic [ROWS-1:0][7:0] a;
  } entry_t;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, nonempty;
  state_t        state, state_nxt;
  logic [FW-1:0] flush_cnt;

  assign push     = in_valid && in_ready;
  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !push) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_w, in_a};
  end

  // in_ready is registered from the post-update count, so a pop while full does not reopen it until the next cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      in_ready <= (count_nxt < DEPTH_W);
    end
  end

  // IDLE pops directly so a lone vector reaches row 0 two cycles after its push
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (nonempty) begin
          pop = 1'b1;
          if (head.last)          state_nxt = FLUSH;
          else if (state == IDLE) state_nxt = STREAM;
        end
      end
      FLUSH:   if (flush_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop && head.last)                         flush_cnt <= FW'(L - 1);
      else if (state == FLUSH && flush_cnt != '0)   flush_cnt <= flush_cnt - FW'(1);
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  logic [ROWS-1:0][7:0] a_raw, a_gated;
  logic [COLS-1:0][7:0] w_raw, w_gated;
  logic [ROWS-1:0]      a_vld;
  logic [COLS-1:0]      w_vld;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    systolic_feeder_lane #(.STAGES(r + 1)) u_lane (
      .clk(clk), .rstn(rstn), .in_vld(pop), .in_data(head.a[r]),
      .out_vld(a_vld[r]), .out_data(a_raw[r])
    );
    assign a_gated[r] = a_vld[r] ? a_raw[r] : 8'h00;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    systolic_feeder_lane #(.STAGES(c + 1)) u_lane (
      .clk(clk), .rstn(rstn), .in_vld(pop), .in_data(head.w[c]),
      .out_vld(w_vld[c]), .out_data(w_raw[c])
    );
    assign w_gated[c] = w_vld[c] ? w_raw[c] : 8'h00;
  end

  assign out_a    = a_gated;
  assign out_w    = w_gated;
  assign out_fire = a_vld;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: per-lane expected-data queues filled at push time, popped by a
// negedge monitor on every fire; directed timing checks around each scenario.

module tb_systolic_feeder;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid, in_ready, in_last, busy, done;
  logic [31:0] in_a, in_w, out_a, out_w;
  logic [3:0]  out_fire;
  logic        s_valid, s_ready, s_last, s_busy, s_done;
  logic [31:0] s_ain, s_win, s_aout, s_wout;
  logic [3:0]  s_fire;

  always #5 clk = ~clk;

  systolic_feeder #(.ROWS(4), .COLS(4), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
    .in_last(in_last), .out_a(out_a), .out_fire(out_fire), .out_w(out_w), .busy(busy), .done(done)
  );

  // Shallow instance so the full-FIFO case is reachable during one tile's flush window
  systolic_feeder #(.ROWS(4), .COLS(4), .DEPTH(4)) dut_s (
    .clk(clk), .rstn(rstn), .in_valid(s_valid), .in_ready(s_ready), .in_a(s_ain), .in_w(s_win),
    .in_last(s_last), .out_a(s_aout), .out_fire(s_fire), .out_w(s_wout), .busy(s_busy), .done(s_done)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_a[4][$];
  logic [7:0] exp_w[4][$];
  logic [7:0] exp_s[$];
  int fire_cyc[4][64];
  int nfire[4];
  int done_cyc = 0, done_cnt = 0, last_fire = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int r = 0; r < 4; r++) n += exp_a[r].size() + exp_w[r].size();
    return n;
  endfunction

  always @(negedge clk) begin
    logic [7:0] av, wv;
    if (mon_en) begin
      for (int r = 0; r < 4; r++) begin
        av = out_a[8*r +: 8];
        wv = out_w[8*r +: 8];
        if (out_fire[r]) begin
          if (exp_a[r].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fire row %0d actual=1 expected=0 (cycle %0d)", r, cyc);
          end else begin
            chk("row_a", {24'h0, av}, {24'h0, exp_a[r].pop_front()});
            chk("col_w", {24'h0, wv}, {24'h0, exp_w[r].pop_front()});
            if (nfire[r] < 64) begin
              fire_cyc[r][nfire[r]] = cyc;
              if (r > 0) chk("skew", cyc, fire_cyc[0][nfire[r]] + r);
            end
            nfire[r]++;
            last_fire = cyc;
          end
        end else begin
          chk("gate_a", {24'h0, av}, 32'h0);
          chk("gate_w", {24'h0, wv}, 32'h0);
        end
      end
      if (done) begin
        chk("done_time", cyc, last_fire + 1);
        chk("done_drained", pending(), 0);
        chk("busy_at_done", {31'h0, busy}, 32'h1);
        done_cyc = cyc;
        done_cnt++;
      end
      if (s_fire[0]) begin
        if (exp_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_unexpected_fire actual=%0h expected=none (cycle %0d)", s_aout[7:0], cyc);
        end else chk("s_order", {24'h0, s_aout[7:0]}, {24'h0, exp_s.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic last);
    in_valid = 1'b1; in_a = a; in_w = w; in_last = last;
    for (int r = 0; r < 4; r++) begin
      exp_a[r].push_back(a[8*r +: 8]);
      exp_w[r].push_back(w[8*r +: 8]);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic s_drive(input logic [31:0] a, input logic last, input bit expect_accept);
    s_valid = 1'b1; s_ain = a; s_win = 32'h0; s_last = last;
    if (expect_accept) exp_s.push_back(a[7:0]);
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int k = 0;
    while (done_cnt == n0 && k < 60) begin
      @(posedge clk); k++;
    end
    if (done_cnt == n0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_pulse expected=pulse (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int t, base, dc;
    for (int r = 0; r < 4; r++) nfire[r] = 0;
    s_valid = 0; s_ain = 0; s_win = 0; s_last = 0;

    // Reset with random upstream activity
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); in_a = $urandom; in_w = $urandom; in_last = 1'($urandom);
      step();
      mon_en = 1;
    end
    rstn = 1'b1; in_valid = 0; in_last = 0;
    @(negedge clk);
    chk("rst_fire", {28'h0, out_fire}, 0);
    chk("rst_a", out_a, 0);
    chk("rst_w", out_w, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_ready", {31'h0, in_ready}, 0);
    step();
    chk("ready_after_rst", {31'h0, in_ready}, 1);

    // Single-vector tile
    t = cyc; base = nfire[0]; dc = done_cnt;
    drive(32'h04030201, 32'h08070605, 1'b1);
    wait_done(dc);
    @(negedge clk);
    chk("busy_fall", {31'h0, busy}, 0);
    chk("single_row0_t", fire_cyc[0][base], t + 2);
    chk("single_row3_t", fire_cyc[3][base], t + 5);
    chk("single_done_t", done_cyc, t + 6);
    step();

    // Six back-to-back vectors
    t = cyc; base = nfire[0]; dc = done_cnt;
    for (int i = 0; i < 6; i++)
      drive(32'h13121110 + i * 32'h10101010, 32'h83828180 + i * 32'h01010101, i == 5);
    wait_done(dc);
    repeat (3) step();
    chk("stream_row0_t", fire_cyc[0][base], t + 2);
    for (int r = 0; r < 4; r++)
      for (int i = 1; i < 6; i++) chk("stream_b2b", fire_cyc[r][base + i], fire_cyc[r][base] + i);
    chk("stream_done_t", done_cyc, t + 11);
    chk("stream_one_done", done_cnt, dc + 1);

    // Bubble between two vectors
    base = nfire[0]; dc = done_cnt;
    drive(32'hA4A3A2A1, 32'hB4B3B2B1, 1'b0);
    step();
    drive(32'hC4C3C2C1, 32'hD4D3D2D1, 1'b1);
    wait_done(dc);
    step();
    for (int r = 0; r < 4; r++) chk("bubble_gap", fire_cyc[r][base + 1] - fire_cyc[r][base], 2);

    // Fill the shallow instance while it flushes a one-vector tile
    t = cyc;
    s_drive(32'h000000A0, 1'b1, 1);
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) chk("s_ready_room", {31'h0, s_ready}, 1);
      s_drive(32'h000000A0 + i, i == 4, 1);
    end
    chk("s_full_ready", {31'h0, s_ready}, 0);
    s_drive(32'h000000EE, 1'b0, 0);
    chk("s_ready_pop_full", {31'h0, s_ready}, 0);
    step();
    chk("s_ready_reopen", {31'h0, s_ready}, 1);
    repeat (20) step();
    chk("s_drained", exp_s.size(), 0);

    // Reset in the middle of a tile
    dc = done_cnt;
    for (int i = 0; i < 3; i++) drive(32'h55545352 + i, 32'h66656463 + i, 1'b0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_a[r].delete(); exp_w[r].delete(); nfire[r] = 0;
    end
    @(negedge clk);
    chk("midrst_fire", {28'h0, out_fire}, 0);
    chk("midrst_busy", {31'h0, busy}, 0);
    chk("midrst_ready", {31'h0, in_ready}, 0);
    repeat (10) step();
    chk("midrst_idle", {31'h0, busy}, 0);
    chk("midrst_no_done", done_cnt, dc);
    chk("midrst_ready_up", {31'h0, in_ready}, 1);

    chk("final_drained", pending() + exp_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
